// File: rtl/lc_tx_sync_filter_pkg.sv
// Shared life-cycle multibit encodings and helpers for the lc_tx sync/filter block.
package lc_tx_sync_filter_pkg;

    localparam int unsigned LcTxW = 4;

    typedef logic [LcTxW-1:0] lc_tx_t;

    // Only these two encodings are legal; every other 4-bit pattern is treated as a fault.
    typedef enum logic [LcTxW-1:0] {
        On  = 4'b1010,
        Off = 4'b0101
    } lc_tx_e;

    localparam lc_tx_t LcTxOn    = lc_tx_t'(On);
    localparam lc_tx_t LcTxOff   = lc_tx_t'(Off);
    localparam lc_tx_t LcTxReset = LcTxOff;

    // True when the value is one of the two legal encodings.
    function automatic logic lc_tx_valid(input lc_tx_t val);
        return (val == LcTxOn) || (val == LcTxOff);
    endfunction

    // Maps any illegal encoding onto the safe Off value.
    function automatic lc_tx_t lc_tx_sanitize(input lc_tx_t val);
        return lc_tx_valid(val) ? val : LcTxOff;
    endfunction

endpackage

// File: rtl/lc_tx_sync_filter_chan.sv
// One lc_tx channel: synchronizer chain, stability filter, commit and sticky error.
module lc_tx_filter_chan
    import lc_tx_sync_filter_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned FilterCnt  = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  lc_tx_t lc_en_i,
    input  logic   err_clr_i,
    output lc_tx_t lc_en_o,
    output logic   stable_o,
    output logic   err_o
);

    localparam int unsigned CntW = $clog2(FilterCnt + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCnt);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    lc_tx_t [SyncStages-1:0] sync_q;
    lc_tx_t                  samp;

    lc_tx_t          cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    lc_tx_t          out_d;
    logic            stable_d;
    logic            err_d;

    assign samp = sync_q[SyncStages-1];

    // Synchronizer flop chain; stage 0 captures the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= LcTxReset;
            end
        end else begin
            sync_q[0] <= lc_en_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Candidate tracking, saturating stability count, commit and sticky error next-state.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = lc_en_o;
        err_d  = err_o & ~err_clr_i;

        if (samp != cand_q) begin
            cand_d = samp;
            cnt_d  = CntOne;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
        end

        // A committed illegal value forces Off and sets the error; set beats clear.
        if (cnt_q == CntMax) begin
            out_d = lc_tx_sanitize(cand_q);
            if (!lc_tx_valid(cand_q)) begin
                err_d = 1'b1;
            end
        end

        // Stable tracks the count being loaded, so it rises together with the final count step.
        stable_d = (cnt_d == CntMax);
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q   <= LcTxReset;
            cnt_q    <= '0;
            lc_en_o  <= LcTxReset;
            stable_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            lc_en_o  <= out_d;
            stable_o <= stable_d;
            err_o    <= err_d;
        end
    end

endmodule

// File: rtl/lc_tx_sync_filter.sv
// Multi-channel lc_tx synchronizer / glitch filter with replicated outputs per channel.
module lc_tx_sync_filter
    import lc_tx_sync_filter_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned NumCopies   = 1,
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned FilterCnt   = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NumChannels-1:0][LcTxW-1:0]            lc_en_i,
    input  logic [NumChannels-1:0]                       err_clr_i,
    output logic [NumChannels-1:0][NumCopies-1:0][LcTxW-1:0] lc_en_o,
    output logic [NumChannels-1:0]                       stable_o,
    output logic [NumChannels-1:0]                       err_o
);

    lc_tx_t [NumChannels-1:0] chan_out;

    // Independent filter per channel; copies are wired from the single registered value.
    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_chan
        lc_tx_filter_chan #(
            .SyncStages (SyncStages),
            .FilterCnt  (FilterCnt)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .lc_en_i   (lc_en_i[ch]),
            .err_clr_i (err_clr_i[ch]),
            .lc_en_o   (chan_out[ch]),
            .stable_o  (stable_o[ch]),
            .err_o     (err_o[ch])
        );

        for (genvar cp = 0; cp < NumCopies; cp++) begin : g_copy
            assign lc_en_o[ch][cp] = chan_out[ch];
        end
    end

endmodule
